regbank4_write: RTL and testbench

- Write side of the 4-entry register bank whose read side is the 2-level 4:1 mux tree.
- Decodes a 2-bit write address into one-hot enables through a 1:2 demux tree: level 1 on wr_addr[1], level 2 on wr_addr[0]. This mirrors the read mux's sel[1]/sel[0] split.
- Holds the four WIDTH-bit registers, per-entry valid bits and a write-acknowledge pulse.
- Optionally hardwires entry 3 as a zero register, matching the XZR convention.

---
 rtl/regbank4_write.sv | 86 ++++++++
 tb/tb_regbank4_write.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/regbank4_write.sv
// Write side of the 4-entry register bank: demux-tree address decode, data registers,
// per-entry valid flags and registered write acknowledge / error pulses.
module regbank4_write #(
  parameter int unsigned WIDTH     = 64,
  parameter bit          ZERO_LAST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_valid,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [3:0]       valid,
  output logic [3:0]       wr_onehot,
  output logic             wr_ack,
  output logic             wr_err
);

  // Entry 3 is the hardwired zero register when ZERO_LAST is set.
  localparam logic [3:0] ZeroMask = ZERO_LAST ? 4'b1000 : 4'b0000;

  logic [1:0]       lvl1;
  logic [3:0]       dec;
  logic [3:0]       accept;
  logic             discard;
  logic [3:0]       valid_d;

  logic [WIDTH-1:0] data_q [4];
  logic [3:0]       valid_q;
  logic [3:0]       onehot_q;
  logic             ack_q;
  logic             err_q;

  // 1:2 demux on wr_addr[1], then 1:2 demux on wr_addr[0], matching the read mux split.
  always_comb begin
    lvl1[1] = wr_en & wr_addr[1];
    lvl1[0] = wr_en & ~wr_addr[1];
    dec[3]  = lvl1[1] & wr_addr[0];
    dec[2]  = lvl1[1] & ~wr_addr[0];
    dec[1]  = lvl1[0] & wr_addr[0];
    dec[0]  = lvl1[0] & ~wr_addr[0];
  end

  always_comb begin
    accept  = dec & ~ZeroMask;
    discard = |(dec & ZeroMask);
    // Clear takes effect first so a same-cycle write leaves only its own bit set.
    valid_d = (clr_valid ? 4'b0000 : valid_q) | accept;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
      valid_q  <= 4'b0000;
      onehot_q <= 4'b0000;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept[i]) begin
          data_q[i] <= wr_data;
        end
      end
      valid_q  <= valid_d;
      onehot_q <= accept;
      ack_q    <= |accept;
      err_q    <= discard;
    end
  end

  assign q0        = data_q[0];
  assign q1        = data_q[1];
  assign q2        = data_q[2];
  assign q3        = ZERO_LAST ? '0 : data_q[3];
  assign valid     = valid_q & ~ZeroMask;
  assign wr_onehot = onehot_q;
  assign wr_ack    = ack_q;
  assign wr_err    = ZERO_LAST ? err_q : 1'b0;

endmodule

// File: tb/tb_regbank4_write.sv
// Bench for regbank4_write: one instance with a normal entry 3 and one with the zero
// register, both driven from the same stimulus and compared against a simple array model.
module tb_regbank4_write;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [1:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic         clr_valid;

  logic [W-1:0] nq0, nq1, nq2, nq3, zq0, zq1, zq2, zq3;
  logic [3:0]   nvalid, zvalid, nonehot, zonehot;
  logic         nack, zack, nerr, zerr;

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 = ZERO_LAST=0, index 1 = ZERO_LAST=1.
  logic [W-1:0] m_q     [2][4];
  logic [3:0]   m_valid [2];
  logic [3:0]   m_oh    [2];
  logic         m_ack   [2];
  logic         m_err   [2];

  always #5 clk = ~clk;

  regbank4_write #(.WIDTH(W), .ZERO_LAST(1'b0)) dut_n (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_valid(clr_valid), .q0(nq0), .q1(nq1), .q2(nq2), .q3(nq3), .valid(nvalid),
    .wr_onehot(nonehot), .wr_ack(nack), .wr_err(nerr)
  );

  regbank4_write #(.WIDTH(W), .ZERO_LAST(1'b1)) dut_z (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_valid(clr_valid), .q0(zq0), .q1(zq1), .q2(zq2), .q3(zq3), .valid(zvalid),
    .wr_onehot(zonehot), .wr_ack(zack), .wr_err(zerr)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) m_q[k][i] = '0;
      m_valid[k] = 4'b0000;
      m_oh[k]    = 4'b0000;
      m_ack[k]   = 1'b0;
      m_err[k]   = 1'b0;
    end
  endtask

  task automatic model_edge(input logic en, input int addr, input logic [W-1:0] data,
                            input logic clr);
    for (int k = 0; k < 2; k++) begin
      m_oh[k]  = 4'b0000;
      m_ack[k] = 1'b0;
      m_err[k] = 1'b0;
      if (clr) m_valid[k] = 4'b0000;
      if (en) begin
        if (k == 1 && addr == 3) begin
          m_err[k] = 1'b1;
        end else begin
          m_q[k][addr]     = data;
          m_valid[k][addr] = 1'b1;
          m_oh[k]          = 4'(1 << addr);
          m_ack[k]         = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    logic [W-1:0] oq [2][4];
    logic [3:0]   ov [2];
    logic [3:0]   oo [2];
    logic         oa [2];
    logic         oe [2];
    oq[0][0] = nq0; oq[0][1] = nq1; oq[0][2] = nq2; oq[0][3] = nq3;
    oq[1][0] = zq0; oq[1][1] = zq1; oq[1][2] = zq2; oq[1][3] = zq3;
    ov[0] = nvalid;  ov[1] = zvalid;
    oo[0] = nonehot; oo[1] = zonehot;
    oa[0] = nack;    oa[1] = zack;
    oe[0] = nerr;    oe[1] = zerr;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++)
        chk($sformatf("%s_i%0d_q%0d", ph, k, i), oq[k][i], m_q[k][i]);
      chk($sformatf("%s_i%0d_valid", ph, k), W'(ov[k]), W'(m_valid[k]));
      chk($sformatf("%s_i%0d_onehot", ph, k), W'(oo[k]), W'(m_oh[k]));
      chk($sformatf("%s_i%0d_ack", ph, k), W'(oa[k]), W'(m_ack[k]));
      chk($sformatf("%s_i%0d_err", ph, k), W'(oe[k]), W'(m_err[k]));
      chk($sformatf("%s_i%0d_inv", ph, k), W'(oe[k] & (oa[k] | (|oo[k]))), '0);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic cycle(input string ph, input logic en, input int addr,
                       input logic [W-1:0] data, input logic clr);
    wr_en     = en;
    wr_addr   = 2'(addr);
    wr_data   = data;
    clr_valid = clr;
    @(posedge clk);
    model_edge(en, addr, data, clr);
    #1;
    check_all(ph);
  endtask

  initial begin
    logic [W-1:0] rd;
    reset = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = '0; clr_valid = 1'b0;
    model_reset();
    #3;
    check_all("rst_async");
    repeat (3) @(posedge clk);
    #1;
    check_all("rst_hold");
    reset = 1'b0;
    cycle("idle0", 1'b0, 0, '0, 1'b0);
    cycle("idle1", 1'b0, 0, '0, 1'b0);

    // Sweep all four entries back to back.
    for (int a = 0; a < 4; a++) cycle("sweep", 1'b1, a, W'((a + 1) * 'h11), 1'b0);
    chk("sweep_valid_n", W'(nvalid), W'(4'b1111));
    chk("sweep_valid_z", W'(zvalid), W'(4'b0111));
    chk("sweep_q3_n", nq3, W'('h44));
    cycle("sweep_idle", 1'b0, 0, '0, 1'b0);
    chk("sweep_ack_low", W'(nack), '0);

    // Zero register behaviour.
    cycle("zr_clr", 1'b0, 0, '0, 1'b1);
    cycle("zr_w3", 1'b1, 3, W'('hFFFF), 1'b0);
    chk("zr_err", W'(zerr), W'(1));
    chk("zr_ack", W'(zack), '0);
    chk("zr_q3", zq3, '0);
    chk("zr_n_q3", nq3, W'('hFFFF));
    cycle("zr_w1", 1'b1, 1, W'('h5), 1'b0);
    chk("zr_ack2", W'(zack), W'(1));
    chk("zr_valid", W'(zvalid), W'(4'b0010));
    chk("zr_q1", zq1, W'('h5));

    // Clear combined with a write.
    cycle("cw_w0", 1'b1, 0, W'('hA0), 1'b0);
    cycle("cw_w1", 1'b1, 1, W'('hA1), 1'b0);
    cycle("cw_w2", 1'b1, 2, W'('hA2), 1'b0);
    cycle("cw_clrw", 1'b1, 2, W'('hAB), 1'b1);
    chk("cw_valid", W'(nvalid), W'(4'b0100));
    chk("cw_q2", nq2, W'('hAB));
    chk("cw_q0", nq0, W'('hA0));

    // Asynchronous reset in the middle of back-to-back writes.
    cycle("ar_w0", 1'b1, 0, W'('h123), 1'b0);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = W'('h456);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("ar_async");
    @(posedge clk);
    #1;
    check_all("ar_inflight");
    #1;
    reset = 1'b0;
    #1;
    cycle("ar_resume", 1'b1, 1, W'('h789), 1'b0);
    chk("ar_resume_q1", nq1, W'('h789));
    chk("ar_resume_valid", W'(nvalid), W'(4'b0010));

    // Random traffic against the model.
    for (int n = 0; n < 200; n++) begin
      rd = {$urandom, $urandom};
      cycle("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), rd,
            ($urandom_range(0, 7) == 0));
    end
    cycle("final_idle", 1'b0, 0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
